// File: rtl/game_sequencer_if.sv
// rtl/game_sequencer_if.sv - formation, button and status signals of the game sequencer
interface game_sequencer_if;
    logic        button;
    logic        hit;
    logic        player_hit;
    logic [19:0] invaders_array;
    logic [4:0]  invaders_line;
    logic        start;
    logic [2:0]  level;
    logic [9:0]  score;
    logic [1:0]  lives;
    logic        game_over;
    logic [2:0]  state;

    modport master (
        input  button, hit, player_hit, invaders_array, invaders_line,
        output start, level, score, lives, game_over, state
    );

    modport slave (
        output button, hit, player_hit, invaders_array, invaders_line,
        input  start, level, score, lives, game_over, state
    );
endinterface

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - level/lives/score sequencer driving the invaders formation
module game_sequencer #(
    parameter int PAUSE_CYCLES = 25000000,
    parameter int BOTTOM_LINE  = 13,
    parameter int MAX_LEVEL    = 7,
    parameter int START_LIVES  = 3
) (
    input  logic             clk_25MHz,
    input  logic             reset,
    game_sequencer_if.master bus
);
    localparam int CNT_W = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic [2:0]         level_q, level_d;
    logic [9:0]         score_q, score_d;
    logic [1:0]         lives_q, lives_d;
    logic               over_q, over_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cleared_q, cleared_d;
    logic               guard_q, guard_d;
    logic               button_q;
    logic               btn_rise;

    assign btn_rise = bus.button & ~button_q;

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            level_q   <= 3'd0;
            score_q   <= 10'd0;
            lives_q   <= 2'(START_LIVES);
            over_q    <= 1'b0;
            cnt_q     <= '0;
            cleared_q <= 1'b0;
            guard_q   <= 1'b0;
            button_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            level_q   <= level_d;
            score_q   <= score_d;
            lives_q   <= lives_d;
            over_q    <= over_d;
            cnt_q     <= cnt_d;
            cleared_q <= cleared_d;
            guard_q   <= guard_d;
            button_q  <= bus.button;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        score_d   = score_q;
        lives_d   = lives_q;
        cnt_d     = '0;
        cleared_d = cleared_q;
        guard_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btn_rise) state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d = S_PLAY;
                guard_d = 1'b1;
            end
            S_PLAY: begin
                if (bus.hit && score_q != 10'd1023) score_d = score_q + 10'd1;
                // guard_q marks the cycle right after the start pulse, while the formation reloads
                if (!guard_q) begin
                    if (bus.invaders_array == 20'd0) begin
                        cleared_d = 1'b1;
                        state_d   = S_PAUSE;
                    end else if (bus.invaders_line >= 5'(BOTTOM_LINE) || bus.player_hit) begin
                        if (lives_q == 2'd1) begin
                            lives_d = 2'd0;
                            state_d = S_GAME_OVER;
                        end else begin
                            lives_d   = lives_q - 2'd1;
                            cleared_d = 1'b0;
                            state_d   = S_PAUSE;
                        end
                    end
                end
            end
            S_PAUSE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(PAUSE_CYCLES - 1)) begin
                    if (cleared_q && level_q < 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
                    cleared_d = 1'b0;
                    state_d   = S_LAUNCH;
                end
            end
            S_GAME_OVER: begin
                if (btn_rise) begin
                    score_d = 10'd0;
                    level_d = 3'd0;
                    lives_d = 2'(START_LIVES);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        start_d = (state_d == S_LAUNCH);
        over_d  = (state_d == S_GAME_OVER);
    end

    assign bus.start     = start_q;
    assign bus.level     = level_q;
    assign bus.score     = score_q;
    assign bus.lives     = lives_q;
    assign bus.game_over = over_q;
    assign bus.state     = state_q;
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Top-level game controller that sequences the invaders formation block. It waits for the player's start button and launches each level with a one-cycle start pulse to the formation. It watches the formation's alive-mask and descent line to detect level-cleared and invasion conditions, and it counts score from hit pulses. It also tracks lives and level, and drives the level input of the formation and the score/status display logic.

Parameters:
PAUSE_CYCLES, 25000000, inter-level / post-death pause length in clk_25MHz cycles (1 s); benches use 4
BOTTOM_LINE, 13, invaders_line value at or above which the formation has landed
MAX_LEVEL, 7, highest level value; level saturates here
START_LIVES, 3, lives loaded at reset and on new game (1..3)

Ports:
clk_25MHz  in  1  system clock, 25 MHz
reset  in  1  asynchronous, active-high reset
button  in  1  debounced, clk_25MHz-synchronous fire/start button
hit  in  1  one-cycle pulse from formation: a bullet killed an invader
player_hit  in  1  one-cycle pulse: player ship destroyed
invaders_array  in  20  formation alive-mask, 1 = alive
invaders_line  in  5  current vertical line of formation
start  out  1  one-cycle pulse (re)launching formation at current level
level  out  3  current level, to formation
score  out  10  kills, saturating at 1023
lives  out  2  remaining lives
game_over  out  1  high while in GAME_OVER
state  out  3  IDLE=0, LAUNCH=1, PLAY=2, PAUSE=3, GAME_OVER=4

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high. While reset is high: state=IDLE, start=0, level=0, score=0, lives=START_LIVES, game_over=0, pause counter=0, cleared flag=0, button history=0. Asserting reset mid-game aborts immediately to these values.
- Button edge: btn_rise = button & ~button_q, where button_q is registered every cycle.
- IDLE: on btn_rise go to LAUNCH; otherwise stay.
- LAUNCH: lasts exactly 1 cycle with start=1 (start is registered and high for the single cycle state==LAUNCH), then go to PLAY. start=0 in all other states.
- PLAY, guard: array/line checks are ignored on the first PLAY cycle, so the formation has time to reload after the start pulse. hit pulses are counted from the first cycle.
- PLAY, priority order, evaluated each cycle after the guard:
  (1) invaders_array==0: set cleared=1, go to PAUSE.
  (2) else invaders_line>=BOTTOM_LINE or player_hit: if lives==1, set lives=0 and go to GAME_OVER; else lives-=1, cleared=0, go to PAUSE.
  (3) else stay in PLAY.
- Score: in PLAY, each cycle with hit=1 gives score+1, saturating at 1023. This applies even in the cycle that leaves PLAY. hit is ignored in all other states.
- PAUSE: the counter loads 0 on entry and increments each cycle. When counter==PAUSE_CYCLES-1:
  - if cleared, level=min(level+1, MAX_LEVEL);
  - clear cleared and go to LAUNCH.
  - PAUSE therefore lasts exactly PAUSE_CYCLES cycles.
- Level clear at MAX_LEVEL relaunches MAX_LEVEL; there is no wrap.
- GAME_OVER: game_over=1; score, level and lives are held. On btn_rise: score=0, level=0, lives=START_LIVES, game_over=0, go to IDLE. A held button does not retrigger; IDLE needs a fresh rising edge.
- button is ignored in LAUNCH, PLAY and PAUSE.
- Unused state encodings (5..7) recover to IDLE on the next clock.

Test Plan:
- Reset/launch: PAUSE_CYCLES=4; release reset, pulse button 1 cycle -> state goes IDLE→LAUNCH→PLAY on consecutive cycles; start high exactly 1 cycle; level=0, lives=3, score=0.
- Scoring/saturation: in PLAY, 5 hit pulses -> score=5. Preload to 1022 via 3 more hits over 1023 -> score stays 1023. hit during PAUSE -> no change.
- Level clear: in PLAY, drive invaders_array=0 -> PAUSE for exactly 4 cycles, level 0→1, then 1 start pulse. Repeat at level 7 -> level stays 7.
- Simultaneous events: same cycle with invaders_array=0, invaders_line=13, hit=1 -> cleared path taken, lives unchanged, score+1, level increments after pause.
- Life loss / game over: invaders_line=13 with lives=3 -> lives=2, same level relaunched after 4 cycles. Two more player_hit pulses -> lives=0, state=4, game_over=1. Button held high -> stays. Release, press -> IDLE, score=0, level=0, lives=3.
- Async reset mid-PAUSE: assert reset between clock edges -> outputs take reset values immediately, without waiting for a clock edge. After release, state=IDLE.
